// File: rtl/adc_acq_counters_if.sv
// Strobe/flag handshake between the ADC acquisition state machine (master)
// and the counter/config-latch stage (slave).
interface adc_acq_counters_if;
    logic fill_type_mux_en;
    logic burst_cntr_init;
    logic burst_cntr_en;
    logic waveform_cntr_init;
    logic waveform_cntr_en;
    logic waveform_gap_cntr_init;
    logic waveform_gap_cntr_en;
    logic address_cntr_en;
    logic fill_cntr_en;
    logic burst_cntr_zero;
    logic last_waveform;
    logic waveform_gap_zero;

    modport master (
        output fill_type_mux_en,
        output burst_cntr_init,
        output burst_cntr_en,
        output waveform_cntr_init,
        output waveform_cntr_en,
        output waveform_gap_cntr_init,
        output waveform_gap_cntr_en,
        output address_cntr_en,
        output fill_cntr_en,
        input  burst_cntr_zero,
        input  last_waveform,
        input  waveform_gap_zero
    );

    modport slave (
        input  fill_type_mux_en,
        input  burst_cntr_init,
        input  burst_cntr_en,
        input  waveform_cntr_init,
        input  waveform_cntr_en,
        input  waveform_gap_cntr_init,
        input  waveform_gap_cntr_en,
        input  address_cntr_en,
        input  fill_cntr_en,
        output burst_cntr_zero,
        output last_waveform,
        output waveform_gap_zero
    );
endinterface

// File: rtl/adc_acq_counters.sv
// Counter and per-fill config latch stage for the ADC acquisition state machine:
// burst/waveform/gap down-counters with zero flags, plus DDR3 address, fill number and header fields.
module adc_acq_counters #(
    parameter int BURST_W = 23,
    parameter int WFM_W   = 12,
    parameter int GAP_W   = 16,
    parameter int ADDR_W  = 26,
    parameter int FILL_W  = 24
) (
    input  logic                clk,
    input  logic                adc_acq_full_reset,
    adc_acq_counters_if.slave   ctl,
    input  logic [1:0]          fill_type,
    input  logic [BURST_W-1:0]  burst_count0,
    input  logic [BURST_W-1:0]  burst_count1,
    input  logic [BURST_W-1:0]  burst_count2,
    input  logic [BURST_W-1:0]  burst_count3,
    input  logic [WFM_W-1:0]    waveform_count,
    input  logic [GAP_W-1:0]    waveform_gap,
    output logic [BURST_W-1:0]  fill_size,
    output logic [WFM_W-1:0]    waveform_index,
    output logic [FILL_W-1:0]   fill_num,
    output logic [ADDR_W-1:0]   ddr3_wr_addr,
    output logic [ADDR_W-1:0]   fill_word_cnt,
    output logic                cfg_err
);

    logic [BURST_W-1:0] burst_sel;
    logic [BURST_W-1:0] burst_cfg;
    logic [WFM_W-1:0]   wfm_cfg;
    logic               cfg_zero;

    logic [WFM_W-1:0]   wfm_lat;
    logic [GAP_W-1:0]   gap_lat;

    logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt;
    logic [WFM_W-1:0]   wfm_cnt,   wfm_cnt_nxt;
    logic [GAP_W-1:0]   gap_cnt,   gap_cnt_nxt;

    // Config selection; zero counts would stall the state machine, so they are forced to 1.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        burst_sel = burst_count0;
        case (fill_type)
            2'd0:    burst_sel = burst_count0;
            2'd1:    burst_sel = burst_count1;
            2'd2:    burst_sel = burst_count2;
            default: burst_sel = burst_count3;
        endcase
        burst_cfg = (burst_sel == '0)      ? BURST_W'(1) : burst_sel;
        wfm_cfg   = (waveform_count == '0) ? WFM_W'(1)   : waveform_count;
        cfg_zero  = (burst_sel == '0) || (waveform_count == '0);
    end

    // Down-counters: init loads the latched value and beats en; en saturates at 0.
    always_comb begin
        burst_cnt_nxt = burst_cnt;
        if (ctl.burst_cntr_init)
            burst_cnt_nxt = fill_size;
        else if (ctl.burst_cntr_en && (burst_cnt != '0))
            burst_cnt_nxt = burst_cnt - BURST_W'(1);
    end

    always_comb begin
        wfm_cnt_nxt = wfm_cnt;
        if (ctl.waveform_cntr_init)
            wfm_cnt_nxt = wfm_lat;
        else if (ctl.waveform_cntr_en && (wfm_cnt != '0))
            wfm_cnt_nxt = wfm_cnt - WFM_W'(1);
    end

    always_comb begin
        gap_cnt_nxt = gap_cnt;
        if (ctl.waveform_gap_cntr_init)
            gap_cnt_nxt = gap_lat;
        else if (ctl.waveform_gap_cntr_en && (gap_cnt != '0))
            gap_cnt_nxt = gap_cnt - GAP_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (adc_acq_full_reset) begin
            fill_size <= '0;
            wfm_lat   <= '0;
            gap_lat   <= '0;
            cfg_err   <= 1'b0;
        end else if (ctl.fill_type_mux_en) begin
            fill_size <= burst_cfg;
            wfm_lat   <= wfm_cfg;
            gap_lat   <= waveform_gap;
            if (cfg_zero)
                cfg_err <= 1'b1;
        end
    end

    // Flags are registered from the next count so they move on the same edge as the counter.
    always_ff @(posedge clk) begin
        if (adc_acq_full_reset) begin
            burst_cnt             <= '0;
            wfm_cnt               <= '0;
            gap_cnt               <= '0;
            ctl.burst_cntr_zero   <= 1'b1;
            ctl.last_waveform     <= 1'b1;
            ctl.waveform_gap_zero <= 1'b1;
        end else begin
            burst_cnt             <= burst_cnt_nxt;
            wfm_cnt               <= wfm_cnt_nxt;
            gap_cnt               <= gap_cnt_nxt;
            ctl.burst_cntr_zero   <= (burst_cnt_nxt == '0);
            ctl.last_waveform     <= (wfm_cnt_nxt == '0);
            ctl.waveform_gap_zero <= (gap_cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (adc_acq_full_reset)
            waveform_index <= '0;
        else if (ctl.waveform_cntr_init)
            waveform_index <= '0;
        else if (ctl.waveform_cntr_en && (waveform_index != '1))
            waveform_index <= waveform_index + WFM_W'(1);
    end

    // The address wraps freely; the per-fill word count saturates and restarts on each config latch.
    always_ff @(posedge clk) begin
        if (adc_acq_full_reset) begin
            ddr3_wr_addr  <= '0;
            fill_word_cnt <= '0;
        end else begin
            if (ctl.address_cntr_en)
                ddr3_wr_addr <= ddr3_wr_addr + ADDR_W'(1);
            if (ctl.fill_type_mux_en)
                fill_word_cnt <= ctl.address_cntr_en ? ADDR_W'(1) : '0;
            else if (ctl.address_cntr_en && (fill_word_cnt != '1))
                fill_word_cnt <= fill_word_cnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (adc_acq_full_reset)
            fill_num <= '0;
        else if (ctl.fill_cntr_en)
            fill_num <= fill_num + FILL_W'(1);
    end

endmodule
